// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op codes, FSM states and the register-file write-port codes.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIV  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_WB_HI,
        ST_WB_LO
    } state_e;

    localparam logic [1:0] RF_CTRL_FULL = 2'b00;
    localparam logic [1:0] RF_CTRL_LO   = 2'b11;
    localparam logic [4:0] R_LO_ADDR    = 5'd11;

endpackage

// File: rtl/muldiv_iter_core.sv
// Per-cycle iteration datapath: shift-add multiply or restoring
// shift-subtract divide on a 2*XLEN+1 accumulator, with a step counter.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [2*XLEN:0]   load_acc,
    input  logic              step,
    input  logic              op_is_div,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc,
    output logic              last
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [2*XLEN:0] acc_q;
    logic [2*XLEN:0] acc_step;
    logic [CW-1:0]   count;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] diff;

    // Multiply: high half plus optional multiplicand, then shift right.
    // Divide: shift remainder left, subtract divisor, keep it when no borrow.
    always_comb begin
        sum    = acc_q[2*XLEN:XLEN] + {1'b0, (acc_q[0] ? operand : '0)};
        rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff   = {1'b0, rem_sh} - {2'b00, operand};
        if (!op_is_div) begin
            acc_step = {1'b0, sum, acc_q[XLEN-1:1]};
        end else if (!diff[XLEN+1]) begin
            acc_step = {diff[XLEN:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {rem_sh, acc_q[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            count <= '0;
        end else if (load) begin
            acc_q <= load_acc;
            count <= CW'(XLEN);
        end else if (step) begin
            acc_q <= acc_step;
            count <= count - 1'b1;
        end
    end

    assign acc  = acc_q[2*XLEN-1:0];
    assign last = (count == CW'(1));

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit returning its result to the
// register file as two req/gnt write beats (high/quotient, low/remainder).
module muldiv_unit #(
    parameter int         XLEN      = 32,
    parameter logic [4:0] R_LO_ADDR = muldiv_pkg::R_LO_ADDR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [4:0]      dest_addr,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic            wb_req,
    input  logic            wb_gnt,
    output logic            wb_we,
    output logic [1:0]      wb_control,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);
    import muldiv_pkg::*;

    state_e            state, state_nxt;
    op_e               op_in;
    logic              is_div_q, neg_hi_q, neg_lo_q, dbz_q, done_q;
    logic [4:0]        dest_q;
    logic [XLEN-1:0]   opnd_q, res_hi, res_lo;
    logic [2*XLEN-1:0] core_acc;
    logic [2*XLEN:0]   core_load_acc;
    logic              core_step, core_last, accept;
    logic              in_div, in_signed, a_neg, b_neg, in_dbz;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_hi, fix_lo;

    // Divide-by-zero preloads remainder=src_a and quotient=all ones so the
    // answer simply passes through FIX untouched.
    always_comb begin
        op_in     = op_e'(op);
        in_div    = (op_in == OP_DIVU) || (op_in == OP_DIV);
        in_signed = (op_in == OP_MUL)  || (op_in == OP_DIV);
        a_neg     = in_signed & src_a[XLEN-1];
        b_neg     = in_signed & src_b[XLEN-1];
        mag_a     = a_neg ? -src_a : src_a;
        mag_b     = b_neg ? -src_b : src_b;
        in_dbz    = in_div && (src_b == '0);
        accept    = (state == ST_IDLE) && start;
        if (in_dbz) begin
            core_load_acc = {1'b0, src_a, {XLEN{1'b1}}};
        end else if (in_div) begin
            core_load_acc = {{(XLEN+1){1'b0}}, mag_a};
        end else begin
            core_load_acc = {{(XLEN+1){1'b0}}, mag_b};
        end
    end

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk       (clk),
        .rst       (reset),
        .load      (accept),
        .load_acc  (core_load_acc),
        .step      (core_step),
        .op_is_div (is_div_q),
        .operand   (opnd_q),
        .acc       (core_acc),
        .last      (core_last)
    );

    always_comb begin
        prod_fix = neg_hi_q ? -core_acc : core_acc;
        if (dbz_q) begin
            fix_hi = core_acc[XLEN-1:0];
            fix_lo = core_acc[2*XLEN-1:XLEN];
        end else if (is_div_q) begin
            fix_hi = neg_hi_q ? -core_acc[XLEN-1:0] : core_acc[XLEN-1:0];
            fix_lo = neg_lo_q ? -core_acc[2*XLEN-1:XLEN] : core_acc[2*XLEN-1:XLEN];
        end else begin
            fix_hi = prod_fix[2*XLEN-1:XLEN];
            fix_lo = prod_fix[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        wb_req     = 1'b0;
        wb_control = '0;
        wb_addr    = '0;
        wb_data    = '0;
        core_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = in_dbz ? ST_FIX : ST_CALC;
            end
            ST_CALC: begin
                core_step = 1'b1;
                if (core_last) state_nxt = ST_FIX;
            end
            ST_FIX: state_nxt = ST_WB_HI;
            ST_WB_HI: begin
                wb_req     = 1'b1;
                wb_control = RF_CTRL_FULL;
                wb_addr    = dest_q;
                wb_data    = res_hi;
                if (wb_gnt) state_nxt = ST_WB_LO;
            end
            ST_WB_LO: begin
                wb_req     = 1'b1;
                wb_control = RF_CTRL_LO;
                wb_addr    = R_LO_ADDR;
                wb_data    = res_lo;
                if (wb_gnt) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
            dest_q   <= '0;
            opnd_q   <= '0;
            res_hi   <= '0;
            res_lo   <= '0;
        end else begin
            done_q <= (state == ST_WB_LO) && wb_gnt;
            if (accept) begin
                is_div_q <= in_div;
                dest_q   <= dest_addr;
                opnd_q   <= in_div ? mag_b : mag_a;
                neg_hi_q <= a_neg ^ b_neg;
                neg_lo_q <= a_neg;
                dbz_q    <= in_dbz;
            end
            if (state == ST_FIX) begin
                res_hi <= fix_hi;
                res_lo <= fix_lo;
            end
        end
    end

    assign wb_we       = wb_req & wb_gnt;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed and random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    typedef struct packed {
        logic [1:0]  ctl;
        logic [4:0]  addr;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] src_a = '0, src_b = '0;
    logic [4:0]  dest_addr = '0;
    logic        busy, done, div_by_zero, wb_req, wb_we;
    logic        wb_gnt = 1'b1;
    logic [1:0]  wb_control;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t beat_q[$];
    beat_t stall_q[$];

    muldiv_unit #(.XLEN(32), .R_LO_ADDR(5'd11)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .dest_addr   (dest_addr),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .wb_req      (wb_req),
        .wb_gnt      (wb_gnt),
        .wb_we       (wb_we),
        .wb_control  (wb_control),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    always #5 clk = ~clk;

    // Returns {high/quotient, low/remainder}.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        int     sq, sr;
        case (o)
            2'b00: return 64'(a) * 64'(b);
            2'b01: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            2'b10: begin
                if (b == 0) return {32'hFFFF_FFFF, a};
                return {a / b, a % b};
            end
            default: begin
                if (b == 0) return {32'hFFFF_FFFF, a};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sq, sr};
            end
        endcase
    endfunction

    // Issues one op, serves grants with the requested stalls, records the
    // beats, and returns in the cycle where done is seen (or after a bound).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input int hi_st, input int lo_st, input int inj_cyc,
                          output int lat, output int busy_n, output logic dbz_seen);
        int hi_left = hi_st;
        int lo_left = lo_st;
        beat_q.delete();
        stall_q.delete();
        lat = -1;
        dbz_seen = 1'bx;
        op = o; src_a = a; src_b = b; dest_addr = d; start = 1'b1; wb_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        src_a = $urandom; src_b = $urandom; dest_addr = 5'($urandom);
        busy_n = int'(busy);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = cyc;
                dbz_seen = div_by_zero;
                break;
            end
            if (busy) busy_n++;
            if (cyc == inj_cyc) begin
                start = 1'b1; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
            end
            if (wb_req && wb_control == 2'b11) begin
                if (lo_left > 0) begin wb_gnt = 1'b0; lo_left--; end else wb_gnt = 1'b1;
            end else if (wb_req) begin
                if (hi_left > 0) begin wb_gnt = 1'b0; hi_left--; end else wb_gnt = 1'b1;
            end else begin
                wb_gnt = 1'b1;
            end
            #1;
            if (wb_we) beat_q.push_back({wb_control, wb_addr, wb_data});
            else if (wb_req) stall_q.push_back({wb_control, wb_addr, wb_data});
        end
        start = 1'b0;
        wb_gnt = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; wb_gnt = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
        n_vec++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
        n_vec++; if ({wb_req, wb_we} !== 2'b00) begin n_err++; $display("FAIL reset_req_we got=%b want=00", {wb_req, wb_we}); end
        n_vec++; if ({wb_control, wb_addr, wb_data} !== '0) begin n_err++;
            $display("FAIL reset_wb_bus got=%h/%h/%h want=0", wb_control, wb_addr, wb_data); end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [1:0]  t_op [8] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b11, 2'b10};
        logic [31:0] t_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100,
                                  32'd12345, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        logic [31:0] t_b  [8] = '{32'hFFFF_FFFF, 32'd3, 32'd2, 32'd0,
                                  32'd6789, 32'hFFFF_FFFF, 32'd0, 32'd1};
        int lat, bn, elat;
        logic dbz, edbz;
        logic [63:0] exp;
        logic [4:0] d;
        for (int i = 0; i < 8; i++) begin
            d = 5'(i + 3);
            exp = ref_model(t_op[i], t_a[i], t_b[i]);
            edbz = t_op[i][1] && (t_b[i] == 0);
            elat = edbz ? 3 : 35;
            run_op(t_op[i], t_a[i], t_b[i], d, 0, 0, 0, lat, bn, dbz);
            n_vec++; if (lat != elat) begin n_err++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, elat); end
            n_vec++; if (bn != elat) begin n_err++; $display("FAIL dir%0d_busy_cycles got=%0d want=%0d", i, bn, elat); end
            n_vec++; if (dbz !== edbz) begin n_err++; $display("FAIL dir%0d_dbz got=%b want=%b", i, dbz, edbz); end
            n_vec++; if (beat_q.size() != 2) begin n_err++; $display("FAIL dir%0d_beats got=%0d want=2", i, beat_q.size()); end
            else begin
                n_vec++; if (beat_q[0] !== {2'b00, d, exp[63:32]}) begin n_err++;
                    $display("FAIL dir%0d_hi got=%h want=%h", i, beat_q[0], {2'b00, d, exp[63:32]}); end
                n_vec++; if (beat_q[1] !== {2'b11, 5'd11, exp[31:0]}) begin n_err++;
                    $display("FAIL dir%0d_lo got=%h want=%h", i, beat_q[1], {2'b11, 5'd11, exp[31:0]}); end
            end
            @(posedge clk); #1;
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_pulse got=%b want=0", i, done); end
        end
    endtask

    task automatic test_stall;
        int lat, bn;
        logic dbz;
        logic [31:0] a = $urandom, b = $urandom;
        logic [63:0] exp = ref_model(2'b01, a, b);
        run_op(2'b01, a, b, 5'd7, 5, 3, 0, lat, bn, dbz);
        n_vec++; if (lat != 43) begin n_err++; $display("FAIL stall_latency got=%0d want=43", lat); end
        n_vec++; if (beat_q.size() != 2) begin n_err++; $display("FAIL stall_we_pulses got=%0d want=2", beat_q.size()); end
        n_vec++; if (stall_q.size() != 8) begin n_err++; $display("FAIL stall_cycles got=%0d want=8", stall_q.size()); end
        for (int i = 0; i < stall_q.size(); i++) begin
            n_vec++;
            if (stall_q[i] !== ((i < 5) ? {2'b00, 5'd7, exp[63:32]} : {2'b11, 5'd11, exp[31:0]})) begin
                n_err++; $display("FAIL stall_hold%0d got=%h", i, stall_q[i]);
            end
        end
        if (beat_q.size() == 2) begin
            n_vec++; if (beat_q[1] !== {2'b11, 5'd11, exp[31:0]}) begin n_err++;
                $display("FAIL stall_lo got=%h want=%h", beat_q[1], {2'b11, 5'd11, exp[31:0]}); end
        end
    endtask

    task automatic test_start_ignored;
        int lat, bn;
        logic dbz;
        logic [31:0] a = $urandom, b = $urandom_range(1000, 1);
        logic [63:0] exp = ref_model(2'b10, a, b);
        run_op(2'b10, a, b, 5'd20, 0, 0, 5, lat, bn, dbz);
        n_vec++; if (lat != 35) begin n_err++; $display("FAIL ign_latency got=%0d want=35", lat); end
        n_vec++; if (beat_q.size() != 2) begin n_err++; $display("FAIL ign_beats got=%0d want=2", beat_q.size()); end
        else begin
            n_vec++; if ({beat_q[0].data, beat_q[1].data} !== exp) begin n_err++;
                $display("FAIL ign_result got=%h%h want=%h", beat_q[0].data, beat_q[1].data, exp); end
        end
    endtask

    task automatic test_back_to_back;
        int lat, bn;
        logic dbz;
        logic [63:0] e1 = ref_model(2'b10, 32'd77, 32'd0);
        logic [63:0] e2 = ref_model(2'b11, 32'hFFFF_FF00, 32'd9);
        run_op(2'b10, 32'd77, 32'd0, 5'd4, 0, 0, 0, lat, bn, dbz);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_at_done got=%b want=0", busy); end
        n_vec++; if (beat_q.size() != 2 || beat_q[1].data !== e1[31:0]) begin n_err++;
            $display("FAIL b2b_first_lo got=%0d beats want=%h", beat_q.size(), e1[31:0]); end
        run_op(2'b11, 32'hFFFF_FF00, 32'd9, 5'd5, 0, 0, 0, lat, bn, dbz);
        n_vec++; if (lat != 35) begin n_err++; $display("FAIL b2b_latency got=%0d want=35", lat); end
        n_vec++; if (dbz !== 1'b0) begin n_err++; $display("FAIL b2b_dbz_clear got=%b want=0", dbz); end
        n_vec++; if (beat_q.size() != 2 || {beat_q[0].data, beat_q[1].data} !== e2) begin n_err++;
            $display("FAIL b2b_second got=%0d beats want=%h", beat_q.size(), e2); end
    endtask

    task automatic test_reset_mid;
        int lat, bn, we_cnt;
        logic dbz;
        logic [31:0] a = $urandom, b = $urandom;
        logic [63:0] exp = ref_model(2'b01, a, b);
        op = 2'b00; src_a = $urandom; src_b = $urandom; dest_addr = 5'd9; start = 1'b1; wb_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        n_vec++; if ({wb_req, wb_we} !== 2'b00) begin n_err++; $display("FAIL rstmid_req_we got=%b want=00", {wb_req, wb_we}); end
        we_cnt = 0;
        repeat (3) begin
            @(negedge clk); if (wb_we || done) we_cnt++;
            @(posedge clk);
        end
        n_vec++; if (we_cnt != 0) begin n_err++; $display("FAIL rstmid_no_beats got=%0d want=0", we_cnt); end
        #1 reset = 1'b0;
        run_op(2'b01, a, b, 5'd12, 0, 0, 0, lat, bn, dbz);
        n_vec++; if (lat != 35) begin n_err++; $display("FAIL rstmid_next_latency got=%0d want=35", lat); end
        n_vec++; if (beat_q.size() != 2 || {beat_q[0].data, beat_q[1].data} !== exp) begin n_err++;
            $display("FAIL rstmid_next_result got=%0d beats want=%h", beat_q.size(), exp); end
    endtask

    task automatic test_random;
        int lat, bn, hs, ls, elat;
        logic dbz, edbz;
        logic [1:0] o;
        logic [31:0] a, b;
        logic [4:0] d;
        logic [63:0] exp;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            a = $urandom;
            case ($urandom_range(7, 0))
                0: b = 32'd0;
                1: b = $urandom_range(15, 1);
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(5, 0) == 0) a = 32'h8000_0000;
            d = 5'($urandom);
            hs = $urandom_range(3, 0);
            ls = $urandom_range(3, 0);
            exp = ref_model(o, a, b);
            edbz = o[1] && (b == 0);
            elat = (edbz ? 3 : 35) + hs + ls;
            run_op(o, a, b, d, hs, ls, 0, lat, bn, dbz);
            n_vec++; if (lat != elat) begin n_err++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, elat); end
            n_vec++; if (dbz !== edbz) begin n_err++; $display("FAIL rnd%0d_dbz got=%b want=%b", i, dbz, edbz); end
            n_vec++; if (beat_q.size() != 2) begin n_err++; $display("FAIL rnd%0d_beats got=%0d want=2", i, beat_q.size()); end
            else begin
                n_vec++; if (beat_q[0] !== {2'b00, d, exp[63:32]}) begin n_err++;
                    $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h want=%h", i, o, a, b, beat_q[0], {2'b00, d, exp[63:32]}); end
                n_vec++; if (beat_q[1] !== {2'b11, 5'd11, exp[31:0]}) begin n_err++;
                    $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h want=%h", i, o, a, b, beat_q[1], {2'b11, 5'd11, exp[31:0]}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
